// File: rtl/rvfi_trace_buffer.sv
// rvfi_trace_buffer
// Tags every retired instruction from the RVFI port with a 64-bit order
// number and queues it in a small FIFO. A downstream consumer drains the
// FIFO over a valid/ready handshake. When HALT_INSN retires, the halted flag
// sets and further retirements are ignored. The FIFO keeps draining until it
// is empty.
//
// Optional build macro: RVFI_TRACE_TIMESTAMP_EN
//   When defined, a free-running 32-bit cycle counter is added. Each record
//   stores the counter value from its push cycle, and the output out_cycle
//   presents that value for the head record.
//
// DEPTH must be a power of two and at least 2.

module rvfi_trace_buffer #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] HALT_INSN = 32'h0010_0073
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [31:0]              in_insn,
    input  logic [31:0]              in_pc,
    input  logic [4:0]               in_rd_addr,
    input  logic [31:0]              in_rd_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_order,
    output logic [31:0]              out_insn,
    output logic [31:0]              out_pc,
    output logic [4:0]               out_rd_addr,
    output logic [31:0]              out_rd_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     halted
`ifdef RVFI_TRACE_TIMESTAMP_EN
    ,
    output logic [31:0]              out_cycle
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
`ifdef RVFI_TRACE_TIMESTAMP_EN
        logic [31:0] cycle;
`endif
    } rec_t;

    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    rec_t        mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic [63:0] order_q, order_d;
    logic        overflow_q, overflow_d;
    logic        halted_q, halted_d;
`ifdef RVFI_TRACE_TIMESTAMP_EN
    logic [31:0] cycle_q;
`endif

    logic        accept;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    rec_t        wr_rec;
    rec_t        head;

    // Handshake decode. Full and empty come from the pointers; the extra
    // pointer MSB separates the two cases when the indices are equal. A pop
    // frees the head slot in the same cycle, so a full FIFO can still accept
    // a record when a pop happens.
    always_comb begin
        empty  = (wr_ptr_q == rd_ptr_q);
        full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        accept = in_valid && !halted_q;
        pop    = !empty && out_ready;
        push   = accept && (!full || pop);
    end

    // Build the record that an accepted retirement would write.
    always_comb begin
        wr_rec          = '0;
        wr_rec.order    = order_q;
        wr_rec.insn     = in_insn;
        wr_rec.pc       = in_pc;
        wr_rec.rd_addr  = in_rd_addr;
        wr_rec.rd_wdata = in_rd_wdata;
`ifdef RVFI_TRACE_TIMESTAMP_EN
        wr_rec.cycle    = cycle_q;
`endif
    end

    // Next-state logic for the pointers, occupancy, order counter and sticky flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        order_d    = order_q;
        overflow_d = overflow_q;
        halted_d   = halted_q;

        if (push) wr_ptr_d = wr_ptr_q + ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + ONE;

        case ({push, pop})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase

        // A dropped record still uses an order number, so the gap in the
        // sequence shows where records were lost.
        if (accept) begin
            order_d = order_q + 64'd1;
            if (!push)               overflow_d = 1'b1;
            if (in_insn == HALT_INSN) halted_d  = 1'b1;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            order_q    <= '0;
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            order_q    <= order_d;
            overflow_q <= overflow_d;
            halted_q   <= halted_d;
        end
    end

`ifdef RVFI_TRACE_TIMESTAMP_EN
    // Free-running cycle counter used for timestamps. It wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cycle_q <= '0;
        else          cycle_q <= cycle_q + 32'd1;
    end
`endif

    // Record storage. Reset clears the pointers, which is enough to discard
    // the contents, so the array itself has no reset. When the FIFO is full,
    // a write lands on the slot being popped in the same cycle.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_rec;
    end

    // The head record comes straight from storage. It stays stable until it
    // is popped. All payload outputs are forced to zero when the FIFO is empty.
    always_comb begin
        head = '0;
        if (!empty) head = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Output assignments.
    always_comb begin
        out_valid    = (count_q != '0);
        out_order    = head.order;
        out_insn     = head.insn;
        out_pc       = head.pc;
        out_rd_addr  = head.rd_addr;
        out_rd_wdata = head.rd_wdata;
        count        = count_q;
        overflow     = overflow_q;
        halted       = halted_q;
`ifdef RVFI_TRACE_TIMESTAMP_EN
        out_cycle    = head.cycle;
`endif
    end

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Directed testbench for rvfi_trace_buffer (DEPTH = 8).
// Inputs are driven 1 ns after each rising edge. Outputs are checked at that
// same time, so each check sees the state registered at the edge just passed.

module tb_rvfi_trace_buffer;

    localparam logic [31:0] ADDI  = 32'h0010_0093;
    localparam logic [31:0] EBRK  = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_insn = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  in_rd_addr = '0;
    logic [31:0] in_rd_wdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_order;
    logic [31:0] out_insn;
    logic [31:0] out_pc;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_rd_wdata;
    logic [3:0]  count;
    logic        overflow;
    logic        halted;
`ifdef RVFI_TRACE_TIMESTAMP_EN
    logic [31:0] out_cycle;
`endif

    int n_chk = 0;
    int n_err = 0;

    rvfi_trace_buffer #(.DEPTH(8), .HALT_INSN(32'h0010_0073)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_insn      (in_insn),
        .in_pc        (in_pc),
        .in_rd_addr   (in_rd_addr),
        .in_rd_wdata  (in_rd_wdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_order    (out_order),
        .out_insn     (out_insn),
        .out_pc       (out_pc),
        .out_rd_addr  (out_rd_addr),
        .out_rd_wdata (out_rd_wdata),
        .count        (count),
        .overflow     (overflow),
        .halted       (halted)
`ifdef RVFI_TRACE_TIMESTAMP_EN
        ,
        .out_cycle    (out_cycle)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic retire(input logic [31:0] insn, input logic [31:0] pc);
        in_valid    = 1'b1;
        in_insn     = insn;
        in_pc       = pc;
        in_rd_addr  = pc[6:2];
        in_rd_wdata = pc ^ 32'hA5A5_0000;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        chk("rst_valid",    64'(out_valid), 64'd0);
        chk("rst_count",    64'(count),     64'd0);
        chk("rst_overflow", 64'(overflow),  64'd0);
        chk("rst_halted",   64'(halted),    64'd0);
        chk("rst_order",    out_order,      64'd0);

        // ---------------- streaming with ready high ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            retire(ADDI, 32'h100 + 32'(4 * i));
            tick();
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_order", out_order,      64'(i));
            chk("stream_count", 64'(count),     64'd1);
            chk("stream_pc",    64'(out_pc),    64'(32'h100 + 32'(4 * i)));
        end
        chk("stream_insn", 64'(out_insn),     64'(ADDI));
        chk("stream_rd",   64'(out_rd_addr),  64'(5'(32'h108 >> 2)));
        chk("stream_wd",   64'(out_rd_wdata), 64'(32'h108 ^ 32'hA5A5_0000));
        idle();
        tick();
        chk("stream_empty", 64'(out_valid), 64'd0);
        chk("stream_ovf",   64'(overflow),  64'd0);
        chk("stream_pay0",  out_order,      64'd0);

        // ---------------- overflow ----------------
        do_reset();
        for (int i = 0; i < 10; i++) begin
            retire(ADDI, 32'(4 * i));
            tick();
            if (i == 7) begin
                chk("ovf_count8",  64'(count),    64'd8);
                chk("ovf_not_yet", 64'(overflow), 64'd0);
            end
        end
        idle();
        chk("ovf_count", 64'(count),    64'd8);
        chk("ovf_flag",  64'(overflow), 64'd1);
        chk("ovf_head",  out_order,     64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain_order", out_order,     64'(i));
            chk("ovf_drain_pc",    64'(out_pc),   64'(4 * i));
            tick();
        end
        chk("ovf_drained", 64'(count), 64'd0);
        out_ready = 1'b0;
        retire(ADDI, 32'h200);
        tick();
        idle();
        chk("ovf_next_order", out_order,     64'd10);
        chk("ovf_sticky",     64'(overflow), 64'd1);

        // ---------------- full with simultaneous push/pop ----------------
        do_reset();
        for (int i = 0; i < 8; i++) begin
            retire(ADDI, 32'(4 * i));
            tick();
        end
        chk("fp_full", 64'(count), 64'd8);
        chk("fp_h0",   out_order,  64'd0);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            retire(ADDI, 32'h400 + 32'(k));
            tick();
            chk("fp_count", 64'(count),    64'd8);
            chk("fp_ovf",   64'(overflow), 64'd0);
            chk("fp_order", out_order,     64'(k));
        end
        idle();
        for (int i = 4; i < 12; i++) begin
            chk("fp_drain", out_order, 64'(i));
            tick();
        end
        chk("fp_empty", 64'(out_valid), 64'd0);

        // ---------------- halt ----------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            retire(ADDI, 32'(4 * i));
            tick();
        end
        chk("halt_pre", 64'(halted), 64'd0);
        retire(EBRK, 32'h14);
        tick();
        chk("halt_set",   64'(halted), 64'd1);
        chk("halt_count", 64'(count),  64'd6);
        for (int i = 0; i < 2; i++) begin
            retire(ADDI, 32'h80 + 32'(4 * i));
            tick();
        end
        idle();
        chk("halt_ignored", 64'(count), 64'd6);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("halt_drain", out_order, 64'(i));
            if (i == 5) chk("halt_last_insn", 64'(out_insn), 64'(EBRK));
            tick();
        end
        chk("halt_empty", 64'(out_valid), 64'd0);
        retire(ADDI, 32'h300);
        tick();
        idle();
        chk("halt_no_push", 64'(count),  64'd0);
        chk("halt_sticky",  64'(halted), 64'd1);

        // ---------------- asynchronous reset mid-drain ----------------
        do_reset();
        for (int i = 0; i < 9; i++) begin
            retire(ADDI, 32'(4 * i));
            tick();
        end
        idle();
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        chk("ar_count4", 64'(count),    64'd4);
        chk("ar_ovf_pre", 64'(overflow), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_count", 64'(count),     64'd0);
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_ovf",   64'(overflow),  64'd0);
        reset_n = 1'b1;
        retire(ADDI, 32'h500);
        tick();
        idle();
        chk("ar_order", out_order, 64'd0);
        chk("ar_pc",    64'(out_pc), 64'(32'h500));

`ifdef RVFI_TRACE_TIMESTAMP_EN
        // ---------------- timestamps ----------------
        do_reset();
        repeat (10) tick();
        retire(ADDI, 32'h600);
        tick();
        idle();
        repeat (2) tick();
        retire(ADDI, 32'h604);
        tick();
        idle();
        chk("ts_first", 64'(out_cycle), 64'd10);
        out_ready = 1'b1;
        tick();
        chk("ts_second", 64'(out_cycle), 64'd13);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
